// File: rtl/roce_stack_addr_translator.sv
// RoCE address translator: vaddr/qpn lookup against a
// register table, scanned one entry per cycle.
package roce_stack_addr_translator_pkg;
  typedef struct packed {
    logic [63:0] paddr;
    logic [47:0] buflen;
    logic [3:0]  accesdesc;
  } dma_req_t;
endpackage

module roce_stack_addr_translator
  import roce_stack_addr_translator_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              req_addr_valid_i,
  output logic              req_addr_ready_o,
  input  logic [63:0]       req_addr_vaddr_i,
  input  logic [15:0]       req_addr_qpn_i,
  output logic              resp_addr_valid_o,
  input  logic              resp_addr_ready_i,
  output dma_req_t          resp_addr_data_o,
  input  logic              cfg_wr_valid_i,
  output logic              cfg_wr_ready_o,
  input  logic [IDX_W-1:0]  cfg_wr_idx_i,
  input  logic              cfg_wr_en_i,
  input  logic [15:0]       cfg_wr_qpn_i,
  input  logic [63:0]       cfg_wr_vaddr_i,
  input  logic [63:0]       cfg_wr_paddr_i,
  input  logic [47:0]       cfg_wr_buflen_i,
  input  logic [3:0]        cfg_wr_accessdesc_i,
  output logic [15:0]       miss_cnt_o
);

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEARCH,
    T_RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [63:0]      va_q;
  logic [15:0]      qpn_q;
  dma_req_t         resp_q;
  logic [15:0]      miss_q;

  logic             tbl_vld [N_ENTRIES];
  logic [15:0]      tbl_qpn [N_ENTRIES];
  logic [63:0]      tbl_va  [N_ENTRIES];
  logic [63:0]      tbl_pa  [N_ENTRIES];
  logic [47:0]      tbl_len [N_ENTRIES];
  logic [3:0]       tbl_ad  [N_ENTRIES];

  logic [63:0]      e_off;
  logic             e_hit;
  logic             e_last;
  logic             cfg_acc;

  assign req_addr_ready_o  = (state == T_IDLE);
  assign resp_addr_valid_o = (state == T_RESP);
  assign cfg_wr_ready_o    = (state != T_SEARCH);
  assign resp_addr_data_o  = resp_q;
  assign miss_cnt_o        = miss_q;
  assign cfg_acc = cfg_wr_valid_i && cfg_wr_ready_o;

  // Match test for the entry under the scan index.
  // A zero buflen can never satisfy off < buflen.
  always_comb begin
    e_off  = va_q - tbl_va[idx];
    e_hit  = tbl_vld[idx]
          && (tbl_qpn[idx] == qpn_q)
          && (va_q >= tbl_va[idx])
          && (e_off < {16'd0, tbl_len[idx]});
    e_last = (idx == IDX_W'(N_ENTRIES - 1));
  end

  // Lookup FSM with registered response and miss counter.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state  <= T_IDLE;
      idx    <= '0;
      va_q   <= '0;
      qpn_q  <= '0;
      resp_q <= '0;
      miss_q <= '0;
    end else begin
      unique case (state)
        T_IDLE: begin
          if (req_addr_valid_i) begin
            va_q  <= req_addr_vaddr_i;
            qpn_q <= req_addr_qpn_i;
            idx   <= '0;
            state <= T_SEARCH;
          end
        end
        T_SEARCH: begin
          if (e_hit) begin
            resp_q.paddr     <= tbl_pa[idx] + e_off;
            resp_q.buflen    <= tbl_len[idx] - e_off[47:0];
            resp_q.accesdesc <= tbl_ad[idx];
            state            <= T_RESP;
          end else if (e_last) begin
            resp_q <= '0;
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            state  <= T_RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        T_RESP: begin
          if (resp_addr_ready_i) state <= T_IDLE;
        end
        default: state <= T_IDLE;
      endcase
    end
  end

  // Translation table; writes stall only while scanning.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        tbl_vld[i] <= 1'b0;
        tbl_qpn[i] <= '0;
        tbl_va[i]  <= '0;
        tbl_pa[i]  <= '0;
        tbl_len[i] <= '0;
        tbl_ad[i]  <= '0;
      end
    end else if (cfg_acc) begin
      tbl_vld[cfg_wr_idx_i] <= cfg_wr_en_i;
      tbl_qpn[cfg_wr_idx_i] <= cfg_wr_qpn_i;
      tbl_va[cfg_wr_idx_i]  <= cfg_wr_vaddr_i;
      tbl_pa[cfg_wr_idx_i]  <= cfg_wr_paddr_i;
      tbl_len[cfg_wr_idx_i] <= cfg_wr_buflen_i;
      tbl_ad[cfg_wr_idx_i]  <= cfg_wr_accessdesc_i;
    end
  end

endmodule

// File: tb/tb_roce_stack_addr_translator.sv
// Directed bench for roce_stack_addr_translator.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_roce_stack_addr_translator;
  import roce_stack_addr_translator_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_vaddr = '0;
  logic [15:0] req_qpn = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  dma_req_t    resp_data;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_idx = '0;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_qpn = '0;
  logic [63:0] cfg_vaddr = '0;
  logic [63:0] cfg_paddr = '0;
  logic [47:0] cfg_buflen = '0;
  logic [3:0]  cfg_ad = '0;
  logic [15:0] miss_cnt;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  dma_req_t held;

  roce_stack_addr_translator #(.N_ENTRIES(N)) dut (
    .clk_i               (clk),
    .aresetn_i           (aresetn),
    .req_addr_valid_i    (req_valid),
    .req_addr_ready_o    (req_ready),
    .req_addr_vaddr_i    (req_vaddr),
    .req_addr_qpn_i      (req_qpn),
    .resp_addr_valid_o   (resp_valid),
    .resp_addr_ready_i   (resp_ready),
    .resp_addr_data_o    (resp_data),
    .cfg_wr_valid_i      (cfg_valid),
    .cfg_wr_ready_o      (cfg_ready),
    .cfg_wr_idx_i        (cfg_idx),
    .cfg_wr_en_i         (cfg_en),
    .cfg_wr_qpn_i        (cfg_qpn),
    .cfg_wr_vaddr_i      (cfg_vaddr),
    .cfg_wr_paddr_i      (cfg_paddr),
    .cfg_wr_buflen_i     (cfg_buflen),
    .cfg_wr_accessdesc_i (cfg_ad),
    .miss_cnt_o          (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] i, input logic en,
                         input logic [15:0] q, input logic [63:0] va,
                         input logic [63:0] pa, input logic [47:0] len,
                         input logic [3:0] ad);
    cfg_idx = i; cfg_en = en; cfg_qpn = q;
    cfg_vaddr = va; cfg_paddr = pa;
    cfg_buflen = len; cfg_ad = ad;
  endtask

  // Single write from IDLE (ready is high there).
  task automatic cfg_wr(input logic [3:0] i, input logic en,
                        input logic [15:0] q, input logic [63:0] va,
                        input logic [63:0] pa, input logic [47:0] len,
                        input logic [3:0] ad);
    set_cfg(i, en, q, va, pa, len, ad);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Issue a request; returns cycles until resp valid.
  task automatic lookup(input logic [63:0] va, input logic [15:0] q,
                        output int cyc);
    req_vaddr = va; req_qpn = q; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_miss", 64'(miss_cnt), 64'd0);
    chk("rst_paddr", resp_data.paddr, 64'd0);
    aresetn = 1'b1;
    tick();

    // Hit on entry 0.
    cfg_wr(4'd0, 1'b1, 16'd5, 64'h1000, 64'h8000_0000, 48'h100, 4'h3);
    lookup(64'h1040, 16'd5, lat);
    chk("e0_lat", 64'(lat), 64'd2);
    chk("e0_paddr", resp_data.paddr, 64'h8000_0040);
    chk("e0_buflen", 64'(resp_data.buflen), 64'hC0);
    chk("e0_ad", 64'(resp_data.accesdesc), 64'h3);
    take_resp();
    chk("e0_idle", 64'(req_ready), 64'd1);

    // Same entry moved to index 7.
    cfg_wr(4'd0, 1'b0, 16'd5, 64'h1000, 64'h8000_0000, 48'h100, 4'h3);
    cfg_wr(4'd7, 1'b1, 16'd5, 64'h1000, 64'h8000_0000, 48'h100, 4'h3);
    lookup(64'h1000, 16'd5, lat);
    chk("e7_lat", 64'(lat), 64'd9);
    chk("e7_paddr", resp_data.paddr, 64'h8000_0000);
    chk("e7_buflen", 64'(resp_data.buflen), 64'h100);
    take_resp();

    // Exactly at buffer end: miss.
    lookup(64'h1100, 16'd5, lat);
    chk("end_lat", 64'(lat), 64'd17);
    chk("end_paddr", resp_data.paddr, 64'd0);
    chk("end_buflen", 64'(resp_data.buflen), 64'd0);
    chk("end_ad", 64'(resp_data.accesdesc), 64'd0);
    chk("end_miss", 64'(miss_cnt), 64'd1);
    take_resp();

    // Wrong qpn: miss.
    lookup(64'h1040, 16'd6, lat);
    chk("qpn_lat", 64'(lat), 64'd17);
    chk("qpn_paddr", resp_data.paddr, 64'd0);
    chk("qpn_miss", 64'(miss_cnt), 64'd2);
    take_resp();

    // Overlapping entries 2 and 4: lowest index wins.
    cfg_wr(4'd2, 1'b1, 16'd9, 64'h2000, 64'hA000, 48'h1000, 4'h1);
    cfg_wr(4'd4, 1'b1, 16'd9, 64'h2000, 64'hB000, 48'h2000, 4'h2);
    lookup(64'h2010, 16'd9, lat);
    chk("ov2_lat", 64'(lat), 64'd4);
    chk("ov2_paddr", resp_data.paddr, 64'hA010);
    chk("ov2_buflen", 64'(resp_data.buflen), 64'hFF0);
    chk("ov2_ad", 64'(resp_data.accesdesc), 64'h1);
    take_resp();
    cfg_wr(4'd2, 1'b0, 16'd9, 64'h2000, 64'hA000, 48'h1000, 4'h1);
    lookup(64'h2010, 16'd9, lat);
    chk("ov4_lat", 64'(lat), 64'd6);
    chk("ov4_paddr", resp_data.paddr, 64'hB010);
    chk("ov4_buflen", 64'(resp_data.buflen), 64'h1FF0);
    chk("ov4_ad", 64'(resp_data.accesdesc), 64'h2);
    chk("ov4_miss", 64'(miss_cnt), 64'd2);

    // Hold response 5 cycles with a config write in RESP.
    set_cfg(4'd4, 1'b0, 16'd0, 64'd0, 64'd0, 48'd0, 4'd0);
    cfg_valid = 1'b1;
    chk("resp_cfg_ready", 64'(cfg_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      cfg_valid = 1'b0;
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_paddr", resp_data.paddr, 64'hB010);
      chk("hold_buflen", 64'(resp_data.buflen), 64'h1FF0);
    end
    take_resp();
    // Entry 4 now invalid: miss.
    lookup(64'h2010, 16'd9, lat);
    chk("inv4_lat", 64'(lat), 64'd17);
    chk("inv4_miss", 64'(miss_cnt), 64'd3);
    take_resp();

    // Config write stalls during SEARCH.
    cfg_wr(4'd4, 1'b1, 16'd9, 64'h2000, 64'hB000, 48'h2000, 4'h2);
    req_vaddr = 64'h2020; req_qpn = 16'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    set_cfg(4'd3, 1'b1, 16'd9, 64'h2000, 64'hC000, 48'h100, 4'h4);
    cfg_valid = 1'b1;
    chk("srch_cfg_ready", 64'(cfg_ready), 64'd0);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("srch_lat", 64'(lat), 64'd6);
    chk("srch_paddr", resp_data.paddr, 64'hB020);
    chk("srch_cfg_ready_r", 64'(cfg_ready), 64'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    cfg_valid = 1'b0;
    lookup(64'h2020, 16'd9, lat);
    chk("e3_lat", 64'(lat), 64'd5);
    chk("e3_paddr", resp_data.paddr, 64'hC020);
    chk("e3_buflen", 64'(resp_data.buflen), 64'hE0);
    chk("e3_ad", 64'(resp_data.accesdesc), 64'h4);
    take_resp();

    // Reset in cycle 3 of a search.
    req_vaddr = 64'h1000; req_qpn = 16'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    aresetn = 1'b0;
    #1;
    chk("mrst_req_ready", 64'(req_ready), 64'd1);
    chk("mrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mrst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("mrst_miss", 64'(miss_cnt), 64'd0);
    tick();
    aresetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_quiet", 64'(resp_valid), 64'd0);
    end
    lookup(64'h1000, 16'd5, lat);
    chk("post_rst_lat", 64'(lat), 64'd17);
    chk("post_rst_paddr", resp_data.paddr, 64'd0);
    chk("post_rst_miss", 64'(miss_cnt), 64'd1);
    take_resp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/roce_stack_addr_translator.md
# roce_stack_addr_translator

Virtual-to-physical address translation responder for the RoCE stack wrapper. It serves the address-lookup handshake issued by the request handler. It accepts a (vaddr, qpn) lookup and scans a register-based translation table one entry per cycle. It returns a `dma_req_t` response carrying the physical address, remaining buffer length and access descriptor. Table entries are programmed over a separate config write port, driven by the host control path.

## Interface
Parameters:
- `N_ENTRIES`, default 16: number of table entries; a power of two, range 2..64.
- `IDX_W`, default `$clog2(N_ENTRIES)`: width of the entry index.

Ports:
- `clk_i`  in  1  Single clock.
- `aresetn_i`  in  1  Asynchronous, active-low reset.
- `req_addr_valid_i`  in  1  Lookup request valid.
- `req_addr_ready_o`  out  1  Lookup request ready.
- `req_addr_vaddr_i`  in  64  Virtual address to translate.
- `req_addr_qpn_i`  in  16  Queue pair number of the request.
- `resp_addr_valid_o`  out  1  Response valid.
- `resp_addr_ready_i`  in  1  Response ready.
- `resp_addr_data_o`  out  `dma_req_t`  Response fields: `paddr`[63:0], `buflen`[47:0], `accesdesc`[3:0].
- `cfg_wr_valid_i`  in  1  Table write valid.
- `cfg_wr_ready_o`  out  1  Table write ready.
- `cfg_wr_idx_i`  in  `IDX_W`  Index of the entry to write.
- `cfg_wr_en_i`  in  1  Entry valid bit; 0 invalidates the entry.
- `cfg_wr_qpn_i`  in  16  Entry QPN.
- `cfg_wr_vaddr_i`  in  64  Entry virtual base address.
- `cfg_wr_paddr_i`  in  64  Entry physical base address.
- `cfg_wr_buflen_i`  in  48  Entry buffer length in bytes.
- `cfg_wr_accessdesc_i`  in  4  Entry access descriptor.
- `miss_cnt_o`  out  16  Count of lookup misses; saturates at 16'hFFFF.

## Operation
- States: T_IDLE, T_SEARCH, T_RESP.
- `req_addr_ready_o` = (state == T_IDLE). `resp_addr_valid_o` = (state == T_RESP). `cfg_wr_ready_o` = (state != T_SEARCH).
- T_IDLE:
  - On `req_addr_valid_i`, register vaddr and qpn, clear the scan index, and go to T_SEARCH.
- T_SEARCH: each cycle, evaluate entry[idx]. An entry matches when all of the following hold:
  - the entry valid bit is set;
  - entry qpn equals the request qpn;
  - vaddr ≥ entry vaddr;
  - off = vaddr − entry vaddr (64-bit unsigned) is less than the zero-extended buflen.
- Hit response, registered at the next edge, then go to T_RESP:
  - `paddr` = entry paddr + off, modulo 2^64;
  - `buflen` = entry buflen − off[47:0];
  - `accesdesc` = entry access descriptor.
- Lowest-index match wins: the scan stops at the first hit.
- No match at idx = N_ENTRIES−1:
  - response is `paddr` = 0, `buflen` = 0, `accesdesc` = 4'h0;
  - increment `miss_cnt_o` (saturating);
  - go to T_RESP.
- T_RESP: hold the response stable until `resp_addr_ready_i`, then go to T_IDLE.
- Config writes: on `cfg_wr_valid_i && cfg_wr_ready_o`, all fields of entry[`cfg_wr_idx_i`] update at the clock edge.
- Entries with buflen 0 never match.

## Timing
- Reset (asynchronous assert):
  - state T_IDLE; all entry valid bits 0; response register 0; `miss_cnt_o` 0.
  - Outputs: `req_addr_ready_o` = 1, `resp_addr_valid_o` = 0, `cfg_wr_ready_o` = 1.
- Reset asserted mid-search or mid-response aborts the lookup. No response is produced after reset deasserts.
- Latency: with request accepted in cycle 0, entry k is evaluated in cycle k+1.
  - Hit on entry k: `resp_addr_valid_o` first high in cycle k+2.
  - Miss: `resp_addr_valid_o` first high in cycle N_ENTRIES+1.
- Response handshake: if `resp_addr_ready_i` is high in the first T_RESP cycle, valid is high for exactly one cycle. The next request can be accepted in the following cycle.
- Back-to-back throughput: one lookup per (search cycles + 2) cycles, minimum.
- Simultaneous request and config write in T_IDLE: both are accepted. The write is visible to that lookup, because the search starts the next cycle.
- Config write during T_RESP is accepted. The held response is unaffected.
- Config write during T_SEARCH stalls: `cfg_wr_ready_o` = 0.
- The miss counter increments on the cycle of the T_SEARCH→T_RESP transition for a miss. It holds at 16'hFFFF.

## Test plan
- Entry 0: qpn 5, vaddr 0x1000, paddr 0x8000_0000, buflen 0x100, accessdesc 0x3. Lookup (0x1040, 5) -> valid in cycle 2; paddr 0x8000_0040, buflen 0xC0, accesdesc 0x3.
- Same entry placed at index 7: lookup (0x1000, 5) -> valid in cycle 9; paddr 0x8000_0000, buflen 0x100.
- Lookup (0x1100, 5), exactly at the buffer end; and lookup (0x1040, 6), wrong qpn -> each gives valid in cycle 17 (N=16), response all-zero, `miss_cnt_o` increments by 1 per lookup.
- Overlapping entries 2 and 4 both match -> response uses entry 2's fields. Then invalidate entry 2 with `cfg_wr_en_i` = 0 -> the repeat lookup uses entry 4.
- Hold `resp_addr_ready_i` low for 5 cycles -> response stable, `req_addr_ready_o` = 0 throughout. Config write during T_SEARCH -> `cfg_wr_ready_o` = 0 and the write completes once the block leaves T_SEARCH.
- Assert `aresetn_i` in cycle 3 of a search -> all outputs return to reset values, entries are invalidated, and a following lookup misses.
